// File: rtl/lcd_uart_tx_if.sv
// Byte handshake between the LCD sequencer and the serial transmitter.
`timescale 1ns / 1ps

interface lcd_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/lcd_uart_tx.sv
// 8N1 serial transmitter for the serial LCD, LSB first, idle high.
// The baud square wave is sampled as data in the clk_50 domain; each of its rising
// edges becomes a one-cycle tick that advances the frame by one bit.
// A small byte FIFO lets the sequencer stream strings back-to-back.
`timescale 1ns / 1ps

module lcd_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_50,
  input  logic                          rst_n,
  input  logic                          clk_9p6k,
  lcd_uart_tx_if.slave                  tx_bus,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Baud synchronizer and edge detect.
  logic s1_q, s2_q, s3_q;
  logic tick;

  // FIFO storage and bookkeeping.
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            tx_ready;
  logic            push, pop;
  logic            have_byte;

  // Frame engine.
  state_e     state_q, state_d;
  logic       txd_q, txd_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       last_stop;

  // Three-flop chain on the asynchronous baud level; s3 only delays s2 for the edge detect.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_9p6k;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  // Ready and pop eligibility come from the registered count only, so a full FIFO
  // refuses a write even when a pop happens in the same cycle.
  assign tx_ready        = (count_q < CntW'(FIFO_DEPTH));
  assign tx_bus.tx_ready = tx_ready;
  assign push            = tx_bus.tx_valid & tx_ready;
  assign have_byte       = (count_q != '0);

  // Occupancy next-state: push and pop together leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO pointers and count; pointers wrap naturally since the depth is a power of 2.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Byte storage; contents are don't-care after reset because the pointers are cleared.
  always_ff @(posedge clk_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_bus.tx_data;
    end
  end

  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

  // Frame sequencing: every transition and txd change happens only in a tick cycle.
  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    pop        = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (have_byte) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = StStart;
          end
        end
        StStart: begin
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
        StData: begin
          if (bit_idx_q != 3'd7) begin
            txd_d     = shift_q[bit_idx_q + 3'd1];
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            txd_d      = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = StStop;
          end
        end
        StStop: begin
          if (!last_stop) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else if (have_byte) begin
            // Chain straight into the next start bit with no idle period.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame state registers; txd resets high so the line idles during reset.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      txd_q      <= 1'b1;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != StIdle);
  assign fifo_count = count_q;

endmodule
